regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the pierogi core. It provides two combinational read ports, one write port and an optional write-to-read bypass. A per-register busy scoreboard lets the issue stage reserve a destination register for an in-flight result and stall dependent reads until the write-back lands. It sits between decode/issue (reads, reservations) and write-back (writes).

---
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two read ports, one write port, optional write bypass
// and a per-register busy scoreboard for in-flight destination registers.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wen,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic wr_zero, rsv_zero;
    logic wr_eff, rsv_set, cnt_inc, cnt_dec;

    assign wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

    // Acceptance looks at the pre-edge busy bit, so a same-cycle write
    // to rsv_addr cannot unblock a reservation.
    assign rsv_ok  = rsv_en & ~rst & ~flush & ~busy_q[rsv_addr];
    assign rsv_set = rsv_ok & ~rsv_zero;
    assign wr_eff  = wen & ~wr_zero;

    assign cnt_inc = rsv_set;
    assign cnt_dec = wr_eff & busy_q[wr_addr]
                   & ~(rsv_set && (rsv_addr == wr_addr));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_eff) busy_d[wr_addr] = 1'b0;
            if (rsv_set) busy_d[rsv_addr] = 1'b1;
            cnt_d = cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_eff) mem_q[wr_addr] <= wr_data;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        rd_busy_a = busy_q[rd_addr_a];
        if ((BYPASS != 0) && wen && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        rd_busy_b = busy_q[rd_addr_b];
        if ((BYPASS != 0) && wen && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = 1'b0;
        end
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard, with a second
// instance built without bypass for latency comparison.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic        wen, rsv_en, flush;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_busy_a, rd_busy_b, rsv_ok;
    logic [4:0]  busy_cnt;

    logic [31:0] nb_data_a, nb_data_b;
    logic        nb_busy_a, nb_busy_b, nb_rsv_ok;
    logic [4:0]  nb_busy_cnt;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
        .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
        .rd_busy_a(nb_busy_a), .rd_busy_b(nb_busy_b),
        .wen(wen), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
        .flush(flush), .busy_cnt(nb_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_DA, K_DB, K_BA, K_BB, K_OK, K_CNT, K_NDA, K_NCNT} kind_t;
    typedef struct {
        string       tag;
        kind_t       k;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.k   = k;
        e.v   = v;
        q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_DA:    return rd_data_a;
            K_DB:    return rd_data_b;
            K_BA:    return {31'd0, rd_busy_a};
            K_BB:    return {31'd0, rd_busy_b};
            K_OK:    return {31'd0, rsv_ok};
            K_CNT:   return {27'd0, busy_cnt};
            K_NDA:   return nb_data_a;
            default: return {27'd0, nb_busy_cnt};
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.k);
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        wr_addr = '0; wr_data = '0; rsv_addr = '0;
    endtask

    // Inputs change at the falling edge; outputs are sampled 3ns later,
    // well before the next rising edge commits the step.
    task automatic go();
        #3;
        drain();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        idle();
        rst = 1'b1;
        rd_addr_a = '0; rd_addr_b = '0;
        @(negedge clk);
        idle();

        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            push($sformatf("rst_da%0d", i), K_DA, 0);
            push($sformatf("rst_db%0d", i), K_DB, 0);
            push($sformatf("rst_ba%0d", i), K_BA, 0);
            push($sformatf("rst_bb%0d", i), K_BB, 0);
            push("rst_cnt", K_CNT, 0);
            go();
        end

        wen = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd_addr_a = 5;
        push("byp_same", K_DA, 32'hDEADBEEF);
        push("nobyp_same", K_NDA, 0);
        go();
        idle();
        push("byp_next", K_DA, 32'hDEADBEEF);
        push("nobyp_next", K_NDA, 32'hDEADBEEF);
        go();

        wen = 1; wr_addr = 0; wr_data = 32'h1234; rd_addr_a = 0;
        rsv_en = 1; rsv_addr = 0;
        push("r0_byp", K_DA, 0);
        push("r0_rsv_ok", K_OK, 1);
        go();
        idle();
        push("r0_data", K_DA, 0);
        push("r0_busy", K_BA, 0);
        push("r0_cnt", K_CNT, 0);
        go();

        rsv_en = 1; rsv_addr = 3; rd_addr_a = 3;
        push("r3_ok", K_OK, 1);
        push("r3_busy_pre", K_BA, 0);
        go();
        push("r3_busy", K_BA, 1);
        push("r3_cnt", K_CNT, 1);
        push("r3_again", K_OK, 0);
        go();
        idle();
        wen = 1; wr_addr = 3; wr_data = 32'h33;
        push("r3_wr_busy", K_BA, 0);
        push("r3_wr_data", K_DA, 32'h33);
        push("r3_wr_cnt", K_CNT, 1);
        go();
        idle();
        rd_addr_b = 5;
        push("r3_done_busy", K_BA, 0);
        push("r3_done_cnt", K_CNT, 0);
        push("r5_keep", K_DB, 32'hDEADBEEF);
        go();

        wen = 1; wr_addr = 7; wr_data = 32'h77;
        rsv_en = 1; rsv_addr = 7; rd_addr_a = 7;
        push("r7_ok", K_OK, 1);
        push("r7_byp", K_DA, 32'h77);
        push("r7_byp_busy", K_BA, 0);
        go();
        idle();
        push("r7_data", K_DA, 32'h77);
        push("r7_busy", K_BA, 1);
        push("r7_cnt", K_CNT, 1);
        go();
        wen = 1; wr_addr = 7; wr_data = 32'h78;
        go();
        idle();

        rsv_en = 1; rsv_addr = 1;
        push("r1_ok", K_OK, 1);
        push("r1_cnt", K_CNT, 0);
        go();
        rsv_addr = 2;
        push("r2_cnt", K_CNT, 1);
        go();
        rsv_addr = 4;
        push("r4_cnt", K_CNT, 2);
        go();
        idle();
        flush = 1; rsv_en = 1; rsv_addr = 9;
        wen = 1; wr_addr = 2; wr_data = 32'h22;
        push("fl_ok", K_OK, 0);
        push("fl_cnt_pre", K_CNT, 3);
        go();
        idle();
        rd_addr_a = 4; rd_addr_b = 2;
        push("fl_busy4", K_BA, 0);
        push("fl_busy2", K_BB, 0);
        push("fl_data2", K_DB, 32'h22);
        push("fl_cnt", K_CNT, 0);
        go();

        rsv_en = 1; rsv_addr = 5; rd_addr_a = 9;
        push("fl_busy9", K_BA, 0);
        push("r5_ok", K_OK, 1);
        go();
        idle();
        wen = 1; wr_addr = 5; wr_data = 32'h55;
        rsv_en = 1; rsv_addr = 6; rd_addr_a = 5;
        push("net_ok", K_OK, 1);
        push("net_cnt_pre", K_CNT, 1);
        push("net_byp", K_DA, 32'h55);
        go();
        idle();
        rd_addr_a = 5; rd_addr_b = 6;
        rsv_en = 1; rsv_addr = 8;
        push("net_busy5", K_BA, 0);
        push("net_busy6", K_BB, 1);
        push("net_cnt", K_CNT, 1);
        push("nb_cnt", K_NCNT, 1);
        push("r8_ok", K_OK, 1);
        go();
        idle();

        rst = 1; rsv_en = 1; rsv_addr = 10;
        wen = 1; wr_addr = 11; wr_data = 32'h99;
        push("rst_rsv_ok", K_OK, 0);
        push("rst_cnt_pre", K_CNT, 2);
        go();
        idle();
        rd_addr_a = 5; rd_addr_b = 6;
        push("rst2_data5", K_DA, 0);
        push("rst2_busy5", K_BA, 0);
        push("rst2_busy6", K_BB, 0);
        push("rst2_cnt", K_CNT, 0);
        push("rst2_nbcnt", K_NCNT, 0);
        go();
        rd_addr_a = 11; rd_addr_b = 8;
        push("rst2_data11", K_DA, 0);
        push("rst2_busy8", K_BB, 0);
        go();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
